// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - registered AES-128 AddRoundKey stage with round-key file and round counter
// Define ADDKEY_SKID_EN to add a one-entry skid register behind a registered in_ready.
module add_round_key_stage #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_wr_en,
   input  logic [3:0]   key_wr_idx,
   input  logic [127:0] key_wr_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [3:0]   out_round,
   output logic         out_last
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   logic [127:0] key_q [0:NR];
   logic [3:0]   rnd;
   logic         accept;
   logic [127:0] sum;

   assign accept = in_valid && in_ready;
   // Key is read before this edge's write lands, so a same-cycle write is not seen.
   assign sum    = in_data ^ key_q[rnd];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i <= NR; i++) key_q[i] <= '0;
      end else if (key_wr_en && key_wr_idx <= LAST_RND) begin
         key_q[key_wr_idx] <= key_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rnd <= '0;
      end else if (accept) begin
         rnd <= (in_last || rnd == LAST_RND) ? 4'd0 : rnd + 4'd1;
      end
   end

`ifdef ADDKEY_SKID_EN
   logic         skid_valid;
   logic [127:0] skid_data;
   logic [3:0]   skid_round;
   logic         skid_last;
   logic         ready_q;
   logic         out_free;

   assign out_free = !out_valid || out_ready;
   assign in_ready = rst_n && ready_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_round  <= '0;
         out_last   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_round <= '0;
         skid_last  <= 1'b0;
         ready_q    <= 1'b1;
      end else if (out_free) begin
         // ready_q is low whenever the skid is full, so no accept competes with the drain.
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            out_round  <= skid_round;
            out_last   <= skid_last;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
         end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= sum;
            out_round  <= rnd;
            out_last   <= in_last;
         end else begin
            out_valid  <= 1'b0;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= sum;
         skid_round <= rnd;
         skid_last  <= in_last;
         ready_q    <= 1'b0;
      end
   end
`else
   assign in_ready = rst_n && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_round <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sum;
         out_round <= rnd;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - randomized self-checking bench for add_round_key_stage against a beat-queue model
module tb_add_round_key_stage;

   localparam int NR = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_wr_en;
   logic [3:0]   key_wr_idx;
   logic [127:0] key_wr_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_round;
   logic         out_last;

   always #5 clk = ~clk;

   add_round_key_stage #(.NR(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_round(out_round), .out_last(out_last)
   );

   typedef struct {
      logic [127:0] data;
      int           round;
      bit           last;
   } beat_t;

   beat_t        exp_q[$];
   logic [127:0] m_key [16];
   int           m_rnd;
   int           n_cmp = 0;
   int           n_bad = 0;
   bit           dut_acc;
   int           n_acc;
   logic [127:0] hold;
   logic [127:0] tmp;

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge with inputs set; returns just after the next falling edge.
   task automatic step();
      bit    exp_ready;
      bit    acc;
      bit    emit;
      beat_t b;
      #1;
      exp_ready = rst_n && (exp_q.size() == 0 || out_ready);
      check("in_ready", 128'(in_ready), 128'(exp_ready));
      dut_acc = in_valid && in_ready;
      acc     = in_valid && exp_ready;
      emit    = (exp_q.size() != 0) && out_ready;
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         m_rnd = 0;
         foreach (m_key[i]) m_key[i] = '0;
      end else begin
         if (emit) void'(exp_q.pop_front());
         if (acc) begin
            b.data  = in_data ^ m_key[m_rnd];
            b.round = m_rnd;
            b.last  = in_last;
            exp_q.push_back(b);
            m_rnd = (in_last || m_rnd == NR) ? 0 : m_rnd + 1;
         end
         if (key_wr_en && int'(key_wr_idx) <= NR) m_key[key_wr_idx] = key_wr_data;
      end
      #1;
      check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("out_data", out_data, exp_q[0].data);
         check("out_round", 128'(out_round), 128'(exp_q[0].round));
         check("out_last", 128'(out_last), 128'(exp_q[0].last));
      end else if (!rst_n) begin
         check("rst_data", out_data, '0);
         check("rst_round", 128'(out_round), '0);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      m_rnd = 0;
      foreach (m_key[i]) m_key[i] = '0;
      @(negedge clk);
      step();
      step();
      check("reset_out_valid", 128'(out_valid), '0);
      rst_n = 1'b1;

      // FIPS-197 round 0 and round 1
      key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      step();
      key_wr_idx = 4'd1; key_wr_data = 128'ha0fafe1788542cb123a339392a6c7605;
      step();
      key_wr_en = 1'b0;
      in_valid = 1'b1; in_data = 128'h3243f6a8885a308d313198a2e0370734;
      step();
      check("fips_r0_data", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      check("fips_r0_round", 128'(out_round), 128'd0);
      in_data = 128'h046681e5e0cb199a48f8d37a2806264c;
      step();
      check("fips_r1_data", out_data, 128'ha49c7ff2689f352b6b5bea43026a5049);
      check("fips_r1_round", 128'(out_round), 128'd1);

      // Same-cycle write to key[2] with a round-2 accept: old (zero) key applies
      key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = rand128();
      tmp = rand128(); in_data = tmp;
      step();
      check("collide_old_key", out_data, tmp);
      key_wr_idx = 4'd15; key_wr_data = rand128(); in_data = rand128();
      step();
      key_wr_en = 1'b0; in_valid = 1'b0;
      step();

      // Counter wrap, then in_last on the third beat
      rst_n = 1'b0; step(); rst_n = 1'b1;
      in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_data = rand128();
         step();
         check("wrap_round", 128'(out_round), 128'(i % (NR + 1)));
      end
      for (int i = 0; i < 4; i++) begin
         in_last = (i == 2);
         in_data = rand128();
         step();
         check("last_round", 128'(out_round), 128'((i < 3) ? i + 1 : 0));
      end
      in_last = 1'b0;

      // Backpressure: drain, then stall 5 cycles with in_valid held high
      in_valid = 1'b0; step();
      out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         in_data = rand128();
         step();
         if (dut_acc) n_acc++;
         if (i == 0) hold = out_data;
         else check("stall_hold", out_data, hold);
      end
      check("stall_accepts", 128'(n_acc), 128'd1);
      out_ready = 1'b1; in_valid = 1'b0;
      step();

      // Reset with a result pending clears output, counter and keys
      in_valid = 1'b1; out_ready = 1'b0; in_data = rand128();
      step();
      rst_n = 1'b0;
      step();
      check("midrst_valid", 128'(out_valid), '0);
      check("midrst_data", out_data, '0);
      rst_n = 1'b1; out_ready = 1'b1; tmp = rand128(); in_data = tmp;
      step();
      check("midrst_key_cleared", out_data, tmp);
      check("midrst_round", 128'(out_round), '0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         key_wr_en   = ($urandom_range(0, 3) == 0);
         key_wr_idx  = 4'($urandom_range(0, 15));
         key_wr_data = rand128();
         in_valid    = ($urandom_range(0, 3) != 0);
         in_data     = rand128();
         in_last     = ($urandom_range(0, 7) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/add_round_key_stage.md
# add_round_key_stage

Registered AddRoundKey stage of the baseline AES-128 datapath, placed directly downstream of the combinational MixColumns logic. It accepts one 128-bit state per handshake, XORs it with the round key for the current round, and presents the result on a registered valid/ready output. It also owns the round-key register file (NR+1 entries) and the per-block round counter that selects the key.

## Interface
- `NR`, default 10: number of cipher rounds. Key file holds entries 0..NR; the round counter wraps after round NR.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `key_wr_en` input 1: write strobe for the round-key file.
- `key_wr_idx` input 4: key entry index; writes with index > NR are ignored.
- `key_wr_data` input 128: round key, same byte order as the state (byte 0 = bits 127:120).
- `in_valid` input 1: upstream state valid.
- `in_ready` output 1: stage can accept a state this cycle.
- `in_data` input 128: state from MixColumns, or the plaintext for round 0.
- `in_last` input 1: beat is the final round of its block; forces the counter to 0 after acceptance.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts result.
- `out_data` output 128: `in_data ^ key[round]`.
- `out_round` output 4: round index used for `out_data`.
- `out_last` output 1: registered copy of `in_last`.

## Operation
- Accept on `in_valid && in_ready`; emit on `out_valid && out_ready`.
- Round counter `rnd` (4 bits) selects `key[rnd]` at the accept cycle. After an accept it becomes 0 if `in_last` is 1 or `rnd == NR`; otherwise `rnd + 1`. `in_last` takes priority.
- Key file: `NR+1` × 128-bit registers, written on `key_wr_en` at the clock edge. An accept in the same cycle as a write to the same index uses the old key. The new key applies from the next cycle.
- Keys written while a block is in flight are allowed. No interlock is provided; software is responsible for ordering.
- The XOR is bitwise, with no width change.
- Output register (`out_data`, `out_round`, `out_last`, `out_valid`) loads on accept. It holds while `out_valid && !out_ready`.
- Without the skid buffer: `in_ready = rst_n && (!out_valid || out_ready)`.

## Timing
- Reset (`rst_n` low at an edge) clears:
  - `out_valid`, `out_data`, `out_round`, `out_last` to 0;
  - `rnd` to 0;
  - all key entries to 0;
  - the skid buffer, if present.
- `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Latency: an accept at edge N gives `out_valid` = 1 after edge N, so one cycle.
- Throughput: one state per cycle while `out_ready` stays high.
- `out_data`, `out_round` and `out_last` must stay stable while `out_valid && !out_ready`.
- Reset mid-block discards the output and skid contents and returns `rnd` to 0. No partial output appears after reset.
- Simultaneous accept and emit in one cycle is legal; the output register reloads with no bubble.

## Configuration
- `ADDKEY_SKID_EN` defined:
  - adds a one-entry skid register;
  - `in_ready` is driven directly from a flop: 1 when the skid is empty, and 0 during reset;
  - if the output stalls while an accept happens, the new result goes into the skid; it moves to the output register on the next `out_ready`;
  - latency stays 1 cycle when not stalled;
  - ordering is preserved;
  - `in_ready` returns to 1 one cycle after the skid drains.
- `ADDKEY_SKID_EN` undefined:
  - no skid register;
  - `in_ready` is the combinational expression given in Operation.

## Test plan
- **Round 0 (FIPS-197 App. B):** load key[0] = 2b7e151628aed2a6abf7158809cf4f3c; send in_data = 3243f6a8885a308d313198a2e0370734 -> out_data = 193de3bea0f4e22b9ac68d2ae9f84808, out_round = 0, one cycle later.
- **Round 1:** key[1] = a0fafe1788542cb123a339392a6c7605; second beat in_data = 046681e5e0cb199a48f8d37a2806264c -> a49c7ff2689f352b6b5bea43026a5049, out_round = 1.
- **Counter wrap:** send 11 back-to-back beats with `in_last` = 0 and `out_ready` = 1 -> out_round runs 0..10, and the 12th beat reports 0. A block with `in_last` on beat 3 -> the next beat reports round 0.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 -> output is stable and no beat is lost or duplicated. Without the skid exactly 1 beat is accepted; with `ADDKEY_SKID_EN` exactly 2.
- **Write collision:** write key[2] in the same cycle as a round-2 accept -> the output uses the old key[2]. Writing idx = 15 -> no entry changes.
- **Reset mid-stream:** pull `rst_n` low for 1 cycle with `out_valid` = 1 -> `out_valid` = 0 and `out_data` = 0 the next cycle, `rnd` = 0, and all keys read back as 0 (XOR with a zero key gives in_data unchanged).
